// File: rtl/reg_file_sb_pkg.sv
// Shared geometry for the register file, ALU and decode: default data/address
// widths and the register count derived from the address width.
package reg_file_sb_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 2;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for in-flight multi-cycle writers, with the
// set-over-clear update and the read-port hazard/stall decode.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd0_addr,
  input  logic [ADDR_W-1:0]        rd1_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     stall,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_next;
  logic             haz0;
  logic             haz1;

  // Clear on writeback first, then set on issue, so a same-cycle issue to the
  // same register keeps it busy for the new producer.
  always_comb begin
    busy_next = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i)))
        busy_next[i] = 1'b0;
      if (iss_en && (iss_addr == ADDR_W'(i)))
        busy_next[i] = 1'b1;
    end
    if (ZERO_REG != 0)
      busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_next;
  end

  // A writeback landing in the same cycle already supplies the operand.
  always_comb begin
    haz0  = busy_q[rd0_addr] && !(wr_en && (wr_addr == rd0_addr));
    haz1  = busy_q[rd1_addr] && !(wr_en && (wr_addr == rd1_addr));
    stall = rd_en && (haz0 || haz1);
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port, write-to-read
// bypass and a busy scoreboard that stalls reads of still-pending operands.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd0_addr,
  input  logic [ADDR_W-1:0]         rd1_addr,
  output logic signed [DATA_W-1:0]  rd0_data,
  output logic signed [DATA_W-1:0]  rd1_data,
  output logic                      rd_valid,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic signed [DATA_W-1:0]  wr_data,
  input  logic                      iss_en,
  input  logic [ADDR_W-1:0]         iss_addr,
  output logic                      stall,
  output logic [(2**ADDR_W)-1:0]    busy_vec
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic signed [DATA_W-1:0] regs [DEPTH];
  logic signed [DATA_W-1:0] rd0_next;
  logic signed [DATA_W-1:0] rd1_next;
  logic                     wr_ok;
  logic                     rd_fire;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd0_addr (rd0_addr),
    .rd1_addr (rd1_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .stall    (stall),
    .busy_vec (busy_vec)
  );

  assign wr_ok   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign rd_fire = rd_en && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A hardwired zero register overrides the bypass even when wr_addr is 0.
  always_comb begin
    rd0_next = regs[rd0_addr];
    rd1_next = regs[rd1_addr];
    if (wr_en && (wr_addr == rd0_addr))
      rd0_next = wr_data;
    if (wr_en && (wr_addr == rd1_addr))
      rd1_next = wr_data;
    if ((ZERO_REG != 0) && (rd0_addr == '0))
      rd0_next = '0;
    if ((ZERO_REG != 0) && (rd1_addr == '0))
      rd1_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_data <= '0;
      rd1_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd0_data <= rd0_next;
        rd1_data <= rd1_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a default instance plus a ZERO_REG=1
// instance driven by the same inputs, checked against hand-computed values.
module tb_reg_file_sb;

  logic              clk;
  logic              rst;
  logic              rd_en;
  logic [1:0]        rd0_addr;
  logic [1:0]        rd1_addr;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic signed [8:0] wr_data;
  logic              iss_en;
  logic [1:0]        iss_addr;

  logic signed [8:0] rd0_data, rd1_data;
  logic              rd_valid, stall;
  logic [3:0]        busy_vec;
  logic signed [8:0] z_rd0_data, z_rd1_data;
  logic              z_rd_valid, z_stall;
  logic [3:0]        z_busy_vec;

  int compared = 0;
  int mismatched = 0;

  localparam logic signed [8:0] M5 = -9'sd5;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .stall(stall), .busy_vec(busy_vec)
  );

  reg_file_sb #(.DATA_W(9), .ADDR_W(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(z_rd0_data), .rd1_data(z_rd1_data), .rd_valid(z_rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .stall(z_stall), .busy_vec(z_busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    rd_en = 0; rd0_addr = 0; rd1_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    iss_en = 0; iss_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    compared++; if (busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0000", busy_vec); end
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got=%b exp=0", rd_valid); end
    @(negedge clk);
    rst = 0;
    rd_en = 1; rd0_addr = 1; rd1_addr = 3;
    tick();
    idle_inputs();
    compared++; if (rd0_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL reset_rd0 got=%0d exp=0", rd0_data); end
    compared++; if (rd1_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL reset_rd1 got=%0d exp=0", rd1_data); end
    compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_read_valid got=%b exp=1", rd_valid); end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 2; wr_data = M5;
    tick();
    idle_inputs();
    rd_en = 1; rd0_addr = 2; rd1_addr = 0;
    tick();
    idle_inputs();
    compared++; if (rd0_data !== M5) begin mismatched++; $display("[TB] FAIL wr_rd_data got=%0d exp=-5", rd0_data); end
    compared++; if (rd1_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL wr_rd_r0 got=%0d exp=0", rd1_data); end
    tick();
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL valid_pulse got=%b exp=0", rd_valid); end
    compared++; if (rd0_data !== M5) begin mismatched++; $display("[TB] FAIL rd_hold got=%0d exp=-5", rd0_data); end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 1; wr_data = 9'sd20;
    tick();
    wr_en = 1; wr_addr = 1; wr_data = 9'sd100;
    rd_en = 1; rd0_addr = 1; rd1_addr = 1;
    tick();
    idle_inputs();
    compared++; if (rd0_data !== 9'sd100) begin mismatched++; $display("[TB] FAIL bypass_rd0 got=%0d exp=100", rd0_data); end
    compared++; if (rd1_data !== 9'sd100) begin mismatched++; $display("[TB] FAIL bypass_rd1 got=%0d exp=100", rd1_data); end
    rd_en = 1; rd0_addr = 1; rd1_addr = 2;
    tick();
    idle_inputs();
    compared++; if (rd0_data !== 9'sd100) begin mismatched++; $display("[TB] FAIL stored_r1 got=%0d exp=100", rd0_data); end
    compared++; if (rd1_data !== M5) begin mismatched++; $display("[TB] FAIL stored_r2 got=%0d exp=-5", rd1_data); end
  endtask

  task automatic test_stall();
    iss_en = 1; iss_addr = 3;
    tick();
    idle_inputs();
    compared++; if (busy_vec !== 4'b1000) begin mismatched++; $display("[TB] FAIL issue_busy got=%b exp=1000", busy_vec); end
    rd_en = 1; rd0_addr = 0; rd1_addr = 3;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_set got=%b exp=1", stall); end
    tick();
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_valid got=%b exp=0", rd_valid); end
    compared++; if (rd1_data !== M5) begin mismatched++; $display("[TB] FAIL stall_hold got=%0d exp=-5", rd1_data); end
    wr_en = 1; wr_addr = 3; wr_data = 9'sd7;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL wb_unstall got=%b exp=0", stall); end
    tick();
    idle_inputs();
    compared++; if (rd1_data !== 9'sd7) begin mismatched++; $display("[TB] FAIL wb_data got=%0d exp=7", rd1_data); end
    compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wb_valid got=%b exp=1", rd_valid); end
    compared++; if (busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL wb_clear got=%b exp=0000", busy_vec); end
  endtask

  task automatic test_set_clear();
    iss_en = 1; iss_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 9'sd33;
    tick();
    idle_inputs();
    compared++; if (busy_vec !== 4'b0100) begin mismatched++; $display("[TB] FAIL set_wins got=%b exp=0100", busy_vec); end
    rd_en = 1; rd0_addr = 2;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL set_wins_stall got=%b exp=1", stall); end
    rd_en = 0;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL no_rd_no_stall got=%b exp=0", stall); end
    iss_en = 1; iss_addr = 1; wr_en = 1; wr_addr = 2; wr_data = 9'sd33;
    tick();
    idle_inputs();
    compared++; if (busy_vec !== 4'b0010) begin mismatched++; $display("[TB] FAIL indep_update got=%b exp=0010", busy_vec); end
    iss_en = 1; iss_addr = 1;
    tick();
    idle_inputs();
    compared++; if (busy_vec !== 4'b0010) begin mismatched++; $display("[TB] FAIL reissue got=%b exp=0010", busy_vec); end
    wr_en = 1; wr_addr = 1; wr_data = -9'sd256;
    tick();
    idle_inputs();
    compared++; if (busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_clear got=%b exp=0000", busy_vec); end
    rd_en = 1; rd0_addr = 2; rd1_addr = 1;
    tick();
    idle_inputs();
    compared++; if (rd0_data !== 9'sd33) begin mismatched++; $display("[TB] FAIL setclr_data got=%0d exp=33", rd0_data); end
    compared++; if (rd1_data !== -9'sd256) begin mismatched++; $display("[TB] FAIL neg_min_data got=%0d exp=-256", rd1_data); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 0; wr_data = 9'sd9; iss_en = 1; iss_addr = 0;
    tick();
    idle_inputs();
    compared++; if (z_busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL zero_busy got=%b exp=0000", z_busy_vec); end
    compared++; if (busy_vec !== 4'b0001) begin mismatched++; $display("[TB] FAIL plain_r0_busy got=%b exp=0001", busy_vec); end
    rd_en = 1; rd0_addr = 0; rd1_addr = 0;
    #1;
    compared++; if (z_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_stall got=%b exp=0", z_stall); end
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL plain_r0_stall got=%b exp=1", stall); end
    tick();
    compared++; if (z_rd0_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL zero_read got=%0d exp=0", z_rd0_data); end
    compared++; if (z_rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_valid got=%b exp=1", z_rd_valid); end
    wr_en = 1; wr_addr = 0; wr_data = 9'sd9;
    tick();
    idle_inputs();
    compared++; if (z_rd0_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL zero_nobypass got=%0d exp=0", z_rd0_data); end
    compared++; if (rd0_data !== 9'sd9) begin mismatched++; $display("[TB] FAIL plain_r0_bypass got=%0d exp=9", rd0_data); end
    compared++; if (busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL plain_r0_clear got=%b exp=0000", busy_vec); end
  endtask

  task automatic test_async_reset();
    iss_en = 1; iss_addr = 1;
    tick();
    idle_inputs();
    rd_en = 1; rd0_addr = 1; rd1_addr = 0;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_rst_stall got=%b exp=1", stall); end
    compared++; if (z_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL z_pre_rst_stall got=%b exp=1", z_stall); end
    #1;
    rst = 1;
    #1;
    compared++; if (busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_busy got=%b exp=0000", busy_vec); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_stall got=%b exp=0", stall); end
    compared++; if (z_busy_vec !== 4'b0000) begin mismatched++; $display("[TB] FAIL z_rst_busy got=%b exp=0000", z_busy_vec); end
    compared++; if (z_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL z_rst_stall got=%b exp=0", z_stall); end
    compared++; if (rd0_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL rst_rd0 got=%0d exp=0", rd0_data); end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    rd_en = 1; rd0_addr = 2; rd1_addr = 3;
    tick();
    idle_inputs();
    compared++; if (rd0_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL rst_cleared_r2 got=%0d exp=0", rd0_data); end
    compared++; if (rd1_data !== 9'sd0) begin mismatched++; $display("[TB] FAIL rst_cleared_r3 got=%0d exp=0", rd1_data); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_set_clear();
    @(negedge clk);
    rst = 1;
    #2;
    rst = 0;
    test_zero_reg();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the processor datapath: DEPTH = 2**ADDR_W signed registers of DATA_W bits, two read ports, one write port.
- Read ports are registered.
- Write-to-read bypass is built in.
- A per-register busy scoreboard lets the issue stage stall on operands still owed by a multi-cycle writer.
- Replaces the fixed 4x9 file; the default parameters match that geometry.

Parameters:
- DATA_W, 9: register and data width in bits, signed.
- ADDR_W, 2: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0: if 1, register 0 is hardwired to zero and is never busy.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rd_en  input  1  read request for both read ports.
- rd0_addr  input  ADDR_W  read port 0 address.
- rd1_addr  input  ADDR_W  read port 1 address.
- rd0_data  output  DATA_W  registered read data, port 0, signed.
- rd1_data  output  DATA_W  registered read data, port 1, signed.
- rd_valid  output  1  pulses for 1 cycle: rd*_data were updated at the last edge.
- wr_en  input  1  write strobe; also the writeback that clears busy.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data, signed.
- iss_en  input  1  issue strobe: marks iss_addr as pending (busy).
- iss_addr  input  ADDR_W  destination register being issued.
- stall  output  1  combinational: the current read cannot complete.
- busy_vec  output  DEPTH  current scoreboard bits, bit i = register i.

Behaviour:
- Reset (async, rst=1): all registers 0; rd0_data = rd1_data = 0; rd_valid = 0; all busy bits 0. Reset asserted mid-operation discards pending writes and issues immediately.
- Write: at the clk edge with wr_en=1, registers[wr_addr] <= wr_data. Latency 1 cycle.
- Read: at the clk edge with rd_en=1 and stall=0, rdN_data <= value at rdN_addr, and rd_valid <= 1. Otherwise rdN_data hold their value and rd_valid <= 0.
- Bypass: if wr_en=1 and wr_addr == rdN_addr in the same cycle, rdN_data takes wr_data, not the old register value. Both ports bypass independently; both may hit the same address.
- Read-port hazard: hazN = busy[rdN_addr] and not (wr_en and wr_addr == rdN_addr). A same-cycle writeback satisfies the operand.
- Stall: stall = rd_en and (haz0 or haz1). It is purely combinational from the inputs and the busy bits. stall=0 whenever rd_en=0.
- Scoreboard:
  - iss_en sets busy[iss_addr] at the edge.
  - wr_en clears busy[wr_addr] at the edge.
  - If both strobes name the same address in the same cycle, set wins: the register stays busy for the new producer.
  - Different addresses update independently.
  - Re-issuing an address that is already busy leaves it busy (no counting).
  - A write to a non-busy register is legal and leaves it clear.
- Issue during stall: iss_en is accepted regardless of stall; gating issue on stall is the controller's job.
- ZERO_REG=1, register 0:
  - Writes are ignored.
  - Reads return 0; no bypass applies even when wr_addr=0.
  - busy[0] is never set; busy_vec[0] is always 0.
  - It never causes stall.
- Arithmetic: none. Data passes through unmodified; sign is preserved, with no extension or truncation.

Decomposition:
- Shared package: the DATA_W and ADDR_W defaults and the DEPTH derivation, shared with the ALU and decode.
- One sub-module is natural: reg_scoreboard, which holds the busy bits, the set/clear priority logic and the hazard/stall logic. reg_file_sb instantiates it alongside the storage array and the read registers.

Test Plan:
- Reset then read: assert rst, then rd_en with rd0_addr=1, rd1_addr=3 -> rd0_data=0, rd1_data=0, rd_valid=1, busy_vec=0.
- Write then read: write -5 to r2; next cycle read rd0_addr=2 -> rd0_data=-5 one cycle after the read.
- Bypass: wr_en with r1=100 in the same cycle as rd_en with rd0_addr=1 and rd1_addr=1 -> both ports show 100 after that edge, not the old value.
- Scoreboard stall:
  - Issue r3, then rd_en with rd1_addr=3 -> stall=1, rd_valid=0, rd1_data held.
  - Next cycle wr_en r3=7 together with the read -> stall=0, rd1_data=7, busy_vec[3]=0.
- Simultaneous set/clear: iss_en and wr_en both on r2 in the same cycle -> busy_vec[2]=1 afterwards, and a subsequent read of r2 stalls.
- ZERO_REG=1 with an asynchronous reset mid-stall:
  - Write 9 to r0 and issue r0 -> a read of r0 returns 0 and stall=0.
  - Separately, with r1 busy and stalling, assert rst -> busy_vec=0 and stall drops immediately.
